// File: rtl/irq_agg_pkg.sv
// Shared constants for the interrupt aggregator: register addresses,
// ACTIVE word layout and source-count limits.
package irq_agg_pkg;

  localparam int MAX_SRC = 16;
  localparam int REG_W   = 16;

  localparam logic [2:0] ADDR_RAW     = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;

  localparam int ACTIVE_VALID_BIT = 15;

  // One bit per implemented source; used to zero unimplemented register bits.
  function automatic logic [REG_W-1:0] src_valid_mask(input int n);
    logic [REG_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: two-flop input pipeline, rising-edge detect and the
// pending flop (level tracks the input, edge latches until cleared).
module irq_src_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic src_i,
  input  logic edge_mode_i,
  input  logic force_i,
  input  logic clear_i,
  output logic raw_o,
  output logic pending_o
);

  logic src_q;
  logic src_qq;
  logic mode_prev_q;
  logic pending_q;
  logic pending_d;
  logic rise;

  assign rise = src_q & ~src_qq;

  // The cycle after switching into edge mode discards the level-mode value,
  // so only a later rise (or a force) can set the bit.
  always_comb begin
    pending_d = src_q;
    if (edge_mode_i) begin
      if (mode_prev_q) pending_d = rise | force_i | (pending_q & ~clear_i);
      else             pending_d = rise | force_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q       <= 1'b0;
      src_qq      <= 1'b0;
      mode_prev_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      src_q       <= src_i;
      src_qq      <= src_q;
      mode_prev_q <= edge_mode_i;
      pending_q   <= pending_d;
    end
  end

  assign raw_o     = src_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source pending capture, mask, registered
// CPU irq and lowest-index priority report.
module irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter int          NUM_SRC    = 8,
  parameter logic [15:0] RESET_MASK = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [REG_W-1:0] SRC_VALID = src_valid_mask(NUM_SRC);

  logic               wr_en;
  logic [REG_W-1:0]   mask_q, mask_d;
  logic [REG_W-1:0]   mode_q, mode_d;
  logic [REG_W-1:0]   readdata_q, readdata_d;
  logic               irq_q, irq_d;
  logic [REG_W-1:0]   raw;
  logic [REG_W-1:0]   pending;
  logic [REG_W-1:0]   pend_masked;
  logic [NUM_SRC-1:0] clear_vec;
  logic [NUM_SRC-1:0] force_vec;
  logic               act_valid;
  logic [3:0]         act_idx;
  logic [REG_W-1:0]   active_word;

  assign wr_en     = chipselect & ~write_n;
  assign clear_vec = (wr_en && address == ADDR_PENDING) ? writedata[NUM_SRC-1:0] : '0;
  assign force_vec = (wr_en && address == ADDR_FORCE)   ? writedata[NUM_SRC-1:0] : '0;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    irq_src_cell u_cell (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_i       (irq_src[gi]),
      .edge_mode_i (mode_q[gi]),
      .force_i     (force_vec[gi]),
      .clear_i     (clear_vec[gi]),
      .raw_o       (raw[gi]),
      .pending_o   (pending[gi])
    );
  end

  if (NUM_SRC < MAX_SRC) begin : g_unused
    assign raw[MAX_SRC-1:NUM_SRC]     = '0;
    assign pending[MAX_SRC-1:NUM_SRC] = '0;
  end

  // Masking with SRC_VALID keeps unimplemented MASK/MODE bits constant zero.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en && address == ADDR_MASK) mask_d = writedata & SRC_VALID;
    if (wr_en && address == ADDR_MODE) mode_d = writedata & SRC_VALID;
  end

  assign pend_masked = pending & mask_q;
  assign irq_d       = |pend_masked;

  always_comb begin
    act_valid = 1'b0;
    act_idx   = 4'd0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (pend_masked[i]) begin
        act_valid = 1'b1;
        act_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    active_word                   = '0;
    active_word[ACTIVE_VALID_BIT] = act_valid;
    active_word[3:0]              = act_idx;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_RAW:     readdata_d = raw;
      ADDR_PENDING: readdata_d = pending;
      ADDR_MASK:    readdata_d = mask_q;
      ADDR_MODE:    readdata_d = mode_q;
      ADDR_ACTIVE:  readdata_d = active_word;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= RESET_MASK & SRC_VALID;
      mode_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: one table row per clock cycle, plus
// hand-built sequences for same-cycle set/clear, FORCE and async reset.
module tb_irq_aggregator;

  localparam logic [2:0] A_RAW = 3'd0, A_PEND = 3'd1, A_MASK = 3'd2,
                         A_MODE = 3'd3, A_ACT = 3'd4, A_FORCE = 3'd5;

  typedef struct {
    logic [7:0]  src;
    int          op;     // 0 idle, 1 read, 2 write
    logic [2:0]  addr;
    logic [15:0] wd;
    logic        crd;
    logic [15:0] erd;
    logic        cirq;
    logic        eirq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq_src;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  irq_aggregator #(.NUM_SRC(8), .RESET_MASK(16'h0181)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(input logic [7:0] src, input int op, input logic [2:0] addr,
                             input logic [15:0] wd, input logic crd, input logic [15:0] erd,
                             input logic cirq, input logic eirq);
    vec_t v;
    v.src = src; v.op = op; v.addr = addr; v.wd = wd;
    v.crd = crd; v.erd = erd; v.cirq = cirq; v.eirq = eirq;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    irq_src    = v.src;
    chipselect = (v.op != 0);
    write_n    = (v.op != 2);
    address    = v.addr;
    writedata  = v.wd;
    @(posedge clk);
    #1;
    if (v.crd)  check($sformatf("row%0d readdata", id), readdata, v.erd);
    if (v.cirq) check($sformatf("row%0d irq", id), {15'b0, irq}, {15'b0, v.eirq});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];

    reset_n = 1'b0; irq_src = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset readdata", readdata, 16'h0000);
    check("reset irq", {15'b0, irq}, 16'h0000);
    #1 reset_n = 1'b1;

    // register defaults, unimplemented bits
    tbl.push_back(V(8'h00, 1, A_MASK, 16'h0000, 1, 16'h0081, 1, 0));
    tbl.push_back(V(8'h00, 1, A_MODE, 16'h0000, 1, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 2, A_MASK, 16'hFFFF, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 1, A_MASK, 16'h0000, 1, 16'h00FF, 1, 0));
    tbl.push_back(V(8'h00, 2, A_MODE, 16'h0001, 0, 16'h0000, 1, 0));
    // edge bit 0 pulse, latency and W1C
    tbl.push_back(V(8'h01, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 1, A_PEND, 16'h0000, 1, 16'h0001, 1, 1));
    tbl.push_back(V(8'h00, 1, A_ACT,  16'h0000, 1, 16'h8000, 1, 1));
    tbl.push_back(V(8'h00, 2, A_PEND, 16'h0001, 0, 16'h0000, 1, 1));
    tbl.push_back(V(8'h00, 1, A_ACT,  16'h0000, 1, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 1, 3'd6,   16'h0000, 1, 16'h0000, 1, 0));
    // level bit 3
    tbl.push_back(V(8'h00, 2, A_MASK, 16'h0008, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h08, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h08, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h08, 1, A_RAW,  16'h0000, 1, 16'h0008, 1, 1));
    tbl.push_back(V(8'h08, 2, A_PEND, 16'h0008, 0, 16'h0000, 1, 1));
    tbl.push_back(V(8'h08, 1, A_PEND, 16'h0000, 1, 16'h0008, 1, 1));
    tbl.push_back(V(8'h00, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 1));
    tbl.push_back(V(8'h00, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 1));
    tbl.push_back(V(8'h00, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0));
    // edge bits 2 and 5, priority and masking
    tbl.push_back(V(8'h00, 2, A_MODE, 16'h0024, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 2, A_MASK, 16'h0024, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h24, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 1, A_ACT,  16'h0000, 1, 16'h8002, 1, 1));
    tbl.push_back(V(8'h00, 2, A_PEND, 16'h0004, 0, 16'h0000, 1, 1));
    tbl.push_back(V(8'h00, 1, A_ACT,  16'h0000, 1, 16'h8005, 1, 1));
    tbl.push_back(V(8'h00, 2, A_MASK, 16'h0004, 0, 16'h0000, 1, 1));
    tbl.push_back(V(8'h00, 1, A_ACT,  16'h0000, 1, 16'h0000, 1, 0));
    tbl.push_back(V(8'h00, 1, A_PEND, 16'h0000, 1, 16'h0020, 1, 0));
    tbl.push_back(V(8'h00, 2, A_PEND, 16'h0020, 0, 16'h0000, 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // edge bit 1: clear in the same cycle as the rise loses to the set
    apply(V(8'h00, 2, A_MODE, 16'h0026, 0, 16'h0000, 1, 0), 100);
    apply(V(8'h02, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0), 101);
    apply(V(8'h02, 2, A_PEND, 16'h0002, 0, 16'h0000, 1, 0), 102);
    apply(V(8'h02, 1, A_PEND, 16'h0000, 1, 16'h0002, 1, 0), 103);
    apply(V(8'h02, 2, A_PEND, 16'h0002, 0, 16'h0000, 1, 0), 104);
    apply(V(8'h02, 1, A_PEND, 16'h0000, 1, 16'h0000, 1, 0), 105);
    apply(V(8'h00, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0), 106);

    // FORCE in edge mode, then ignored in level mode
    apply(V(8'h00, 2, A_MASK,  16'h0010, 0, 16'h0000, 1, 0), 110);
    apply(V(8'h00, 2, A_MODE,  16'h0036, 0, 16'h0000, 1, 0), 111);
    apply(V(8'h00, 2, A_FORCE, 16'h0010, 1, 16'h0000, 1, 0), 112);
    apply(V(8'h00, 1, A_RAW,   16'h0000, 1, 16'h0000, 1, 1), 113);
    apply(V(8'h00, 1, A_ACT,   16'h0000, 1, 16'h8004, 1, 1), 114);
    apply(V(8'h00, 2, A_PEND,  16'h0010, 0, 16'h0000, 1, 1), 115);
    apply(V(8'h00, 2, A_MODE,  16'h0026, 0, 16'h0000, 1, 0), 116);
    apply(V(8'h00, 2, A_FORCE, 16'h0010, 1, 16'h0000, 1, 0), 117);
    apply(V(8'h00, 1, A_PEND,  16'h0000, 1, 16'h0000, 1, 0), 118);
    apply(V(8'h00, 0, A_RAW,   16'h0000, 0, 16'h0000, 1, 0), 119);

    // all eight pending, then asynchronous reset mid-operation
    apply(V(8'h00, 2, A_MODE, 16'h00FF, 0, 16'h0000, 1, 0), 120);
    apply(V(8'h00, 2, A_MASK, 16'h00FF, 0, 16'h0000, 1, 0), 121);
    apply(V(8'hFF, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0), 122);
    apply(V(8'hFF, 0, A_RAW,  16'h0000, 0, 16'h0000, 1, 0), 123);
    apply(V(8'hFF, 1, A_PEND, 16'h0000, 1, 16'h00FF, 1, 1), 124);
    #1 reset_n = 1'b0;
    #1;
    check("async reset readdata", readdata, 16'h0000);
    check("async reset irq", {15'b0, irq}, 16'h0000);
    @(posedge clk);
    #2 reset_n = 1'b1;
    apply(V(8'hFF, 2, A_MODE, 16'h00FF, 1, 16'h0000, 1, 0), 130);
    apply(V(8'hFF, 1, A_PEND, 16'h0000, 1, 16'h0000, 1, 0), 131);
    apply(V(8'hFF, 1, A_PEND, 16'h0000, 1, 16'h00FF, 1, 1), 132);
    apply(V(8'hFF, 1, A_MASK, 16'h0000, 1, 16'h0081, 1, 1), 133);
    apply(V(8'hFF, 1, A_ACT,  16'h0000, 1, 16'h8000, 1, 1), 134);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
